// File: rtl/cpu_pkg.sv
// Shared types and encodings for the cpu_ctrl instruction sequencer and its
// datapath control interface.
package cpu_pkg;

    typedef enum logic [2:0] {
        ST_WAIT      = 3'd0,
        ST_DECODE    = 3'd1,
        ST_GET_A     = 3'd2,
        ST_GET_B     = 3'd3,
        ST_COMPUTE   = 3'd4,
        ST_WRITE_REG = 3'd5,
        ST_WRITE_IMM = 3'd6,
        ST_HALT      = 3'd7
    } state_e;

    localparam logic [2:0] OPC_MOV = 3'b110;
    localparam logic [2:0] OPC_ALU = 3'b101;

    localparam logic [1:0] OP_MOV_REG = 2'b00;
    localparam logic [1:0] OP_MOV_IMM = 2'b10;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_CMP = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_MVN = 2'b11;

    localparam logic [1:0] WB_ALU   = 2'b00;
    localparam logic [1:0] WB_PC    = 2'b01;
    localparam logic [1:0] WB_IMM8  = 2'b10;
    localparam logic [1:0] WB_MDATA = 2'b11;

    typedef struct packed {
        logic       w;
        logic       w_en;
        logic       en_a;
        logic       en_b;
        logic       en_c;
        logic       en_status;
        logic       sel_a;
        logic       sel_b;
        logic [2:0] w_addr;
        logic [2:0] r_addr;
        logic [1:0] alu_op;
        logic [1:0] shift_op;
        logic [1:0] wb_sel;
    } ctrl_t;

    localparam ctrl_t CTRL_ZERO = ctrl_t'(20'd0);
    localparam ctrl_t CTRL_IDLE = ctrl_t'({1'b1, 19'd0});

endpackage

// File: rtl/cpu_ctrl_if.sv
// Instruction input and datapath control bundle driven by cpu_ctrl.
// err exists only when CPU_CTRL_ILLEGAL_TRAP_EN is defined.
interface cpu_ctrl_if;
    logic [15:0] in;
    logic        load;
    logic        s;
    logic        w;
    logic [2:0]  w_addr;
    logic [2:0]  r_addr;
    logic        w_en;
    logic        en_A;
    logic        en_B;
    logic        en_C;
    logic        en_status;
    logic        sel_A;
    logic        sel_B;
    logic [1:0]  ALU_op;
    logic [1:0]  shift_op;
    logic [1:0]  wb_sel;
    logic [15:0] sximm8;
    logic [15:0] sximm5;
`ifdef CPU_CTRL_ILLEGAL_TRAP_EN
    logic        err;
`endif

    modport master (
        input  in, load, s,
        output w, w_addr, r_addr, w_en, en_A, en_B, en_C, en_status,
               sel_A, sel_B, ALU_op, shift_op, wb_sel, sximm8, sximm5
`ifdef CPU_CTRL_ILLEGAL_TRAP_EN
        , output err
`endif
    );

    modport slave (
        output in, load, s,
        input  w, w_addr, r_addr, w_en, en_A, en_B, en_C, en_status,
               sel_A, sel_B, ALU_op, shift_op, wb_sel, sximm8, sximm5
`ifdef CPU_CTRL_ILLEGAL_TRAP_EN
        , input err
`endif
    );
endinterface

// File: rtl/cpu_ctrl_instr_dec.sv
// Combinational instruction decoder: splits the IR into register fields,
// classifies the instruction and sign-extends the immediates.
module instr_dec
    import cpu_pkg::*;
(
    input  logic [15:0] ir,
    output logic [1:0]  op,
    output logic [2:0]  rn,
    output logic [2:0]  rd,
    output logic [2:0]  rm,
    output logic [1:0]  sh,
    output logic        is_mov_imm,
    output logic        is_mov_reg,
    output logic        is_alu,
    output logic        is_cmp,
    output logic        is_mvn,
    output logic [15:0] sximm8,
    output logic [15:0] sximm5
);
    logic [2:0] opcode_s;

    assign opcode_s   = ir[15:13];
    assign op         = ir[12:11];
    assign rn         = ir[10:8];
    assign rd         = ir[7:5];
    assign sh         = ir[4:3];
    assign rm         = ir[2:0];

    assign is_mov_imm = (opcode_s == OPC_MOV) && (op == OP_MOV_IMM);
    assign is_mov_reg = (opcode_s == OPC_MOV) && (op == OP_MOV_REG);
    assign is_alu     = (opcode_s == OPC_ALU);
    assign is_cmp     = is_alu && (op == ALU_CMP);
    assign is_mvn     = is_alu && (op == ALU_MVN);

    assign sximm8     = {{8{ir[7]}}, ir[7:0]};
    assign sximm5     = {{11{ir[4]}}, ir[4:0]};
endmodule

// File: rtl/cpu_ctrl.sv
// Instruction register, decode and control sequencer for the datapath.
// Define CPU_CTRL_ILLEGAL_TRAP_EN to trap illegal encodings in HALT with err.
module cpu_ctrl
    import cpu_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    cpu_ctrl_if.master  bus
);
    state_e      state_r, state_next_s;
    logic [15:0] ir_r, ir_next_s;
    ctrl_t       ctrl_r, ctrl_next_s;
    logic [15:0] sximm8_r, sximm5_r;
    logic [15:0] sximm8_s, sximm5_s;
    logic [1:0]  op_s, sh_s;
    logic [2:0]  rn_s, rd_s, rm_s;
    logic        is_mov_imm_s, is_mov_reg_s, is_alu_s, is_cmp_s, is_mvn_s;
`ifdef CPU_CTRL_ILLEGAL_TRAP_EN
    logic        err_r;
`endif

    // Outputs are registered from the next state, so decoding must see the
    // IR value that will be present after this edge (load+s in WAIT).
    instr_dec u_dec (
        .ir         (ir_next_s),
        .op         (op_s),
        .rn         (rn_s),
        .rd         (rd_s),
        .rm         (rm_s),
        .sh         (sh_s),
        .is_mov_imm (is_mov_imm_s),
        .is_mov_reg (is_mov_reg_s),
        .is_alu     (is_alu_s),
        .is_cmp     (is_cmp_s),
        .is_mvn     (is_mvn_s),
        .sximm8     (sximm8_s),
        .sximm5     (sximm5_s)
    );

    // IR capture is only allowed while idle.
    always_comb begin
        ir_next_s = ir_r;
        if ((state_r == ST_WAIT) && bus.load) begin
            ir_next_s = bus.in;
        end else begin
            ir_next_s = ir_r;
        end
    end

    // Sequencer next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_WAIT:      state_next_s = bus.s ? ST_DECODE : ST_WAIT;
            ST_DECODE: begin
                if (is_mov_imm_s) begin
                    state_next_s = ST_WRITE_IMM;
                end else if (is_mov_reg_s || is_mvn_s) begin
                    state_next_s = ST_GET_B;
                end else if (is_alu_s) begin
                    state_next_s = ST_GET_A;
                end else begin
`ifdef CPU_CTRL_ILLEGAL_TRAP_EN
                    state_next_s = ST_HALT;
`else
                    state_next_s = ST_WAIT;
`endif
                end
            end
            ST_GET_A:     state_next_s = ST_GET_B;
            ST_GET_B:     state_next_s = ST_COMPUTE;
            ST_COMPUTE:   state_next_s = is_cmp_s ? ST_WAIT : ST_WRITE_REG;
            ST_WRITE_REG: state_next_s = ST_WAIT;
            ST_WRITE_IMM: state_next_s = ST_WAIT;
`ifdef CPU_CTRL_ILLEGAL_TRAP_EN
            ST_HALT:      state_next_s = ST_HALT;
`else
            ST_HALT:      state_next_s = ST_WAIT;
`endif
            default:      state_next_s = ST_WAIT;
        endcase
    end

    // Moore control decode for the state being entered; WRITE_REG keeps the
    // COMPUTE operand selects because the datapath result gate is combinational.
    always_comb begin
        ctrl_next_s = CTRL_ZERO;
        case (state_next_s)
            ST_WAIT:      ctrl_next_s.w = 1'b1;
            ST_GET_A: begin
                ctrl_next_s.r_addr = rn_s;
                ctrl_next_s.en_a   = 1'b1;
            end
            ST_GET_B: begin
                ctrl_next_s.r_addr = rm_s;
                ctrl_next_s.en_b   = 1'b1;
            end
            ST_COMPUTE: begin
                ctrl_next_s.sel_a     = is_mov_reg_s;
                ctrl_next_s.alu_op    = is_mov_reg_s ? ALU_ADD : op_s;
                ctrl_next_s.shift_op  = sh_s;
                ctrl_next_s.en_c      = ~is_cmp_s;
                ctrl_next_s.en_status = is_cmp_s;
            end
            ST_WRITE_REG: begin
                ctrl_next_s.sel_a    = is_mov_reg_s;
                ctrl_next_s.alu_op   = is_mov_reg_s ? ALU_ADD : op_s;
                ctrl_next_s.shift_op = sh_s;
                ctrl_next_s.en_c     = 1'b1;
                ctrl_next_s.w_en     = 1'b1;
                ctrl_next_s.w_addr   = rd_s;
                ctrl_next_s.wb_sel   = WB_ALU;
            end
            ST_WRITE_IMM: begin
                ctrl_next_s.w_en   = 1'b1;
                ctrl_next_s.w_addr = rn_s;
                ctrl_next_s.wb_sel = WB_IMM8;
            end
            ST_DECODE:    ctrl_next_s = CTRL_ZERO;
            ST_HALT:      ctrl_next_s = CTRL_ZERO;
            default:      ctrl_next_s = CTRL_ZERO;
        endcase
    end

    // State, IR and registered control outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r  <= ST_WAIT;
            ir_r     <= 16'd0;
            ctrl_r   <= CTRL_IDLE;
            sximm8_r <= 16'd0;
            sximm5_r <= 16'd0;
        end else begin
            state_r  <= state_next_s;
            ir_r     <= ir_next_s;
            ctrl_r   <= ctrl_next_s;
            sximm8_r <= sximm8_s;
            sximm5_r <= sximm5_s;
        end
    end

`ifdef CPU_CTRL_ILLEGAL_TRAP_EN
    // Sticky trap flag, cleared only by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_r <= 1'b0;
        end else begin
            err_r <= (state_next_s == ST_HALT);
        end
    end

    assign bus.err = err_r;
`endif

    assign bus.w         = ctrl_r.w;
    assign bus.w_en      = ctrl_r.w_en;
    assign bus.en_A      = ctrl_r.en_a;
    assign bus.en_B      = ctrl_r.en_b;
    assign bus.en_C      = ctrl_r.en_c;
    assign bus.en_status = ctrl_r.en_status;
    assign bus.sel_A     = ctrl_r.sel_a;
    assign bus.sel_B     = ctrl_r.sel_b;
    assign bus.w_addr    = ctrl_r.w_addr;
    assign bus.r_addr    = ctrl_r.r_addr;
    assign bus.ALU_op    = ctrl_r.alu_op;
    assign bus.shift_op  = ctrl_r.shift_op;
    assign bus.wb_sel    = ctrl_r.wb_sel;
    assign bus.sximm8    = sximm8_r;
    assign bus.sximm5    = sximm5_r;
endmodule

// File: tb/tb_cpu_ctrl.sv
// Bench for cpu_ctrl: directed cases plus random instructions, each checked
// cycle by cycle against an expected-observation list built from the ISA rules.
module tb_cpu_ctrl;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    cpu_ctrl_if bus ();
    cpu_ctrl dut (.clk(clk), .reset(reset), .bus(bus));

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] exp_q[$];
    bit exp_halt;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] vec(input logic w, input logic w_en, input logic en_a,
            input logic en_b, input logic en_c, input logic en_st, input logic sel_a,
            input logic sel_b, input logic [2:0] wa, input logic [2:0] ra,
            input logic [1:0] alu, input logic [1:0] sh, input logic [1:0] wb, input logic err);
        return {11'd0, err, w, w_en, en_a, en_b, en_c, en_st, sel_a, sel_b, wa, ra, alu, sh, wb};
    endfunction

    function automatic logic [31:0] v_idle();
        return vec(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 2'd0, 2'd0, 2'd0, 1'b0);
    endfunction

    function automatic logic [31:0] v_zero();
        return 32'd0;
    endfunction

    function automatic logic [31:0] obs_vec();
        logic e;
`ifdef CPU_CTRL_ILLEGAL_TRAP_EN
        e = bus.err;
`else
        e = 1'b0;
`endif
        return vec(bus.w, bus.w_en, bus.en_A, bus.en_B, bus.en_C, bus.en_status, bus.sel_A,
                   bus.sel_B, bus.w_addr, bus.r_addr, bus.ALU_op, bus.shift_op, bus.wb_sel, e);
    endfunction

    function automatic bit is_legal(input logic [15:0] ir);
        return (ir[15:13] == 3'b101) ||
               ((ir[15:13] == 3'b110) && ((ir[12:11] == 2'b10) || (ir[12:11] == 2'b00)));
    endfunction

    // Expected observation after each clock edge, starting with the edge that samples s.
    task automatic build_expect(input logic [15:0] ir);
        logic [2:0] opc, rn, rd, rm;
        logic [1:0] op, sh, aop;
        bit mov;
        opc = ir[15:13]; op = ir[12:11]; rn = ir[10:8]; rd = ir[7:5]; sh = ir[4:3]; rm = ir[2:0];
        exp_q.delete();
        exp_halt = 1'b0;
        exp_q.push_back(v_zero());
        if (opc == 3'b110 && op == 2'b10) begin
            exp_q.push_back(vec(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, rn, 3'd0, 2'd0, 2'd0, 2'b10, 1'b0));
        end else if ((opc == 3'b110 && op == 2'b00) || (opc == 3'b101)) begin
            mov = (opc == 3'b110);
            aop = mov ? 2'b00 : op;
            if (!mov && op != 2'b11)
                exp_q.push_back(vec(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, rn, 2'd0, 2'd0, 2'd0, 1'b0));
            exp_q.push_back(vec(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, rm, 2'd0, 2'd0, 2'd0, 1'b0));
            if (!mov && op == 2'b01) begin
                exp_q.push_back(vec(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 3'd0, aop, sh, 2'd0, 1'b0));
            end else begin
                exp_q.push_back(vec(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, mov, 1'b0, 3'd0, 3'd0, aop, sh, 2'd0, 1'b0));
                exp_q.push_back(vec(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, mov, 1'b0, rd, 3'd0, aop, sh, 2'b00, 1'b0));
            end
        end else begin
`ifdef CPU_CTRL_ILLEGAL_TRAP_EN
            exp_q.push_back(vec(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 2'd0, 2'd0, 2'd0, 1'b1));
            exp_halt = 1'b1;
`endif
        end
        if (!exp_halt) exp_q.push_back(v_idle());
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset(input string tag);
        #2 reset = 1'b1;
        #1 check_val({tag, ".async"}, obs_vec(), v_idle());
        bus.load = 1'b0;
        bus.s    = 1'b0;
        @(posedge clk);
        #2 reset = 1'b0;
        tick();
        check_val({tag, ".idle"}, obs_vec(), v_idle());
        check_val({tag, ".ir0"}, {bus.sximm8, bus.sximm5}, 32'd0);
    endtask

    // noise: 0 quiet, 1 random load/in/s, 2 load of 0xD1FF with s high throughout.
    task automatic run_instr(input logic [15:0] ir, input bit split, input int noise,
                             input int stop_after, input string tag);
        int n;
        build_expect(ir);
        bus.in   = ir;
        bus.load = 1'b1;
        if (split) begin
            bus.s = 1'b0;
            tick();
            check_val({tag, ".load"}, obs_vec(), v_idle());
            bus.load = 1'b0;
        end
        bus.s = 1'b1;
        n = exp_q.size();
        for (int i = 0; i < n; i++) begin
            tick();
            check_val($sformatf("%s.c%0d", tag, i + 1), obs_vec(), exp_q[i]);
            if (i + 1 == stop_after) return;
            case (noise)
                1: begin bus.s = 1'($urandom); bus.load = 1'($urandom); bus.in = 16'($urandom); end
                2: begin bus.s = 1'b1; bus.load = 1'b1; bus.in = 16'hD1FF; end
                default: begin bus.s = 1'b0; bus.load = 1'b0; bus.in = ir; end
            endcase
        end
        check_val({tag, ".sximm8"}, {16'd0, bus.sximm8}, {16'd0, {{8{ir[7]}}, ir[7:0]}});
        check_val({tag, ".sximm5"}, {16'd0, bus.sximm5}, {16'd0, {{11{ir[4]}}, ir[4:0]}});
        if (exp_halt) begin
            bus.s = 1'b1;
            for (int k = 0; k < 3; k++) begin
                tick();
                check_val($sformatf("%s.halt%0d", tag, k), obs_vec(), exp_q[n - 1]);
            end
            apply_reset({tag, ".rst"});
        end
        bus.s    = 1'b0;
        bus.load = 1'b0;
    endtask

    initial begin
        logic [15:0] ir;
        int cls;
        reset    = 1'b1;
        bus.in   = 16'd0;
        bus.load = 1'b0;
        bus.s    = 1'b0;
        tick();
        check_val("reset.out", obs_vec(), v_idle());
        check_val("reset.imm", {bus.sximm8, bus.sximm5}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        tick();

        run_instr(16'hD107, 1'b1, 0, -1, "mov_imm7");
        run_instr(16'hD2FF, 1'b0, 0, -1, "mov_immff");
        run_instr(16'hA0A9, 1'b1, 0, -1, "add");
        run_instr(16'hA902, 1'b0, 0, -1, "cmp");
        run_instr(16'hB8A3, 1'b0, 2, -1, "mvn_hold");
        run_instr(16'hA0A9, 1'b0, 2, -1, "add_hold");
        run_instr(16'hC06B, 1'b0, 0, -1, "mov_reg");
        run_instr(16'hA0A9, 1'b0, 0, 4, "add_abort");
        apply_reset("rst_compute");
        run_instr(16'hD507, 1'b0, 0, 2, "imm_abort");
        apply_reset("rst_wimm");
        run_instr(16'hE000, 1'b0, 0, -1, "illegal");

        for (int t = 0; t < 80; t++) begin
            cls = $urandom_range(0, 3);
            ir  = 16'($urandom);
            case (cls)
                0: ir[15:11] = 5'b11010;
                1: ir[15:11] = 5'b11000;
                2: ir[15:13] = 3'b101;
                default: begin
`ifdef CPU_CTRL_ILLEGAL_TRAP_EN
                    ir[15:13] = 3'b101;
`else
                    for (int g = 0; g < 32 && is_legal(ir); g++) ir = 16'($urandom);
                    if (is_legal(ir)) ir[15:13] = 3'b000;
`endif
                end
            endcase
            run_instr(ir, 1'($urandom), int'($urandom_range(0, 2)), -1, $sformatf("rnd%0d", t));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
